// File: rtl/pipeline_stage_reg.sv
// Parametrised inter-stage pipeline register: DEPTH slots of {valid, payload}
// with stall/flush control and saturating stall/flush event counters.
module pipeline_stage_reg #(
    parameter int unsigned       DATA_W    = 64,
    parameter int unsigned       DEPTH     = 1,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0,
    parameter int unsigned       CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [2:0]        occupancy_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    typedef struct packed {
        logic              v;
        logic [DATA_W-1:0] d;
    } slot_t;

    localparam slot_t BUBBLE = '{v: 1'b0, d: NOP_VALUE};

    generate
        if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
            $error("pipeline_stage_reg: DEPTH must be in 1..4");
        end
    endgenerate

    slot_t            slot_q [DEPTH];
    slot_t            slot_n [DEPTH];
    logic [2:0]       occ_q, occ_n;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_n;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_n;

    // Next-state: flush beats stall, stall beats advance; invalid input becomes a bubble.
    always_comb begin
        slot_n      = slot_q;
        stall_cnt_n = stall_cnt_q;
        flush_cnt_n = flush_cnt_q;
        occ_n       = '0;

        if (flush_i) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                slot_n[k] = BUBBLE;
            end
            if (flush_cnt_q != '1) begin
                flush_cnt_n = flush_cnt_q + CNT_W'(1);
            end
        end else if (stall_i) begin
            if (stall_cnt_q != '1) begin
                stall_cnt_n = stall_cnt_q + CNT_W'(1);
            end
        end else begin
            slot_n[0] = valid_i ? '{v: 1'b1, d: data_i} : BUBBLE;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                slot_n[k] = slot_q[k-1];
            end
        end

        for (int unsigned k = 0; k < DEPTH; k++) begin
            occ_n = occ_n + 3'(slot_n[k].v);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                slot_q[k] <= BUBBLE;
            end
            occ_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            slot_q      <= slot_n;
            occ_q       <= occ_n;
            stall_cnt_q <= stall_cnt_n;
            flush_cnt_q <= flush_cnt_n;
        end
    end

    assign valid_o     = slot_q[DEPTH-1].v;
    assign data_o      = slot_q[DEPTH-1].d;
    assign occupancy_o = occ_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

`ifdef SIM
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!$isunknown({stall_i, flush_i}))
            else $error("pipeline_stage_reg: X on stall_i/flush_i");
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Bench for pipeline_stage_reg: four instances (DEPTH 1..4) share one stimulus
// stream; a per-instance queue scoreboard plus table and hand-written sequences.
module tb_pipeline_stage_reg;

    localparam logic [63:0] NOP1 = 64'h0;
    localparam logic [63:0] NOP2 = 64'h0000_0000_0000_0013;
    localparam logic [63:0] NOP3 = 64'h0;
    localparam logic [63:0] NOP4 = 64'hDEAD_BEEF_0BAD_F00D;

    localparam int          DEP  [4] = '{1, 2, 3, 4};
    localparam logic [63:0] NOPS [4] = '{NOP1, NOP2, NOP3, NOP4};
    localparam logic [15:0] SMAX [4] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0003};

    logic clk = 1'b0;
    logic rst = 1'b1, stall = 1'b0, flush = 1'b0, vin = 1'b0;
    logic [63:0] din = '0;

    always #5 clk = ~clk;

    logic v1, v2, v3, v4;
    logic [63:0] d1, d2, d3, d4;
    logic [2:0] o1, o2, o3, o4;
    logic [15:0] s1, s2, s3, f1, f2, f3;
    logic [1:0] s4, f4;

    pipeline_stage_reg #(.DATA_W(64), .DEPTH(1), .NOP_VALUE(NOP1), .CNT_W(16)) u1 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .valid_i(vin), .data_i(din),
        .valid_o(v1), .data_o(d1), .occupancy_o(o1), .stall_cnt_o(s1), .flush_cnt_o(f1));
    pipeline_stage_reg #(.DATA_W(64), .DEPTH(2), .NOP_VALUE(NOP2), .CNT_W(16)) u2 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .valid_i(vin), .data_i(din),
        .valid_o(v2), .data_o(d2), .occupancy_o(o2), .stall_cnt_o(s2), .flush_cnt_o(f2));
    pipeline_stage_reg #(.DATA_W(64), .DEPTH(3), .NOP_VALUE(NOP3), .CNT_W(16)) u3 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .valid_i(vin), .data_i(din),
        .valid_o(v3), .data_o(d3), .occupancy_o(o3), .stall_cnt_o(s3), .flush_cnt_o(f3));
    pipeline_stage_reg #(.DATA_W(64), .DEPTH(4), .NOP_VALUE(NOP4), .CNT_W(2)) u4 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .valid_i(vin), .data_i(din),
        .valid_o(v4), .data_o(d4), .occupancy_o(o4), .stall_cnt_o(s4), .flush_cnt_o(f4));

    logic        vo [4];
    logic [63:0] dq [4];
    logic [2:0]  oc [4];
    logic [15:0] sc [4];
    logic [15:0] fc [4];

    always_comb begin
        vo[0] = v1; vo[1] = v2; vo[2] = v3; vo[3] = v4;
        dq[0] = d1; dq[1] = d2; dq[2] = d3; dq[3] = d4;
        oc[0] = o1; oc[1] = o2; oc[2] = o3; oc[3] = o4;
        sc[0] = s1; sc[1] = s2; sc[2] = s3; sc[3] = {14'b0, s4};
        fc[0] = f1; fc[1] = f2; fc[2] = f3; fc[3] = {14'b0, f4};
    end

    typedef struct packed {
        logic        v;
        logic [63:0] d;
    } exp_t;

    exp_t        sbq [4][$];
    exp_t        cur [4];
    logic [15:0] sc_exp [4];
    logic [15:0] fc_exp [4];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s u%0d: got %h expected %h (t=%0t)", name, inst + 1, act, exp, $time);
        end
    endtask

    // Restart one instance's expectation: all slots bubbles, DEPTH-1 queued ahead of the output.
    task automatic sb_clear(input int i);
        sbq[i].delete();
        for (int k = 0; k < DEP[i] - 1; k++) sbq[i].push_back('{v: 1'b0, d: NOPS[i]});
        cur[i] = '{v: 1'b0, d: NOPS[i]};
    endtask

    // One clock: drive at negedge, update expectations at the edge, compare 1ns later.
    task automatic step(input logic r, input logic s, input logic f, input logic v, input logic [63:0] d);
        int occ;
        @(negedge clk);
        rst = r; stall = s; flush = f; vin = v; din = d;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (r) begin
                sb_clear(i);
                sc_exp[i] = '0;
                fc_exp[i] = '0;
            end else if (f) begin
                sb_clear(i);
                if (fc_exp[i] != SMAX[i]) fc_exp[i]++;
            end else if (s) begin
                if (sc_exp[i] != SMAX[i]) sc_exp[i]++;
            end else begin
                sbq[i].push_back(v ? '{v: 1'b1, d: d} : '{v: 1'b0, d: NOPS[i]});
                cur[i] = sbq[i].pop_front();
            end
            occ = int'(cur[i].v);
            foreach (sbq[i][k]) occ += int'(sbq[i][k].v);
            chk("valid_o", i, 64'(vo[i]), 64'(cur[i].v));
            chk("data_o", i, dq[i], cur[i].d);
            chk("occupancy_o", i, 64'(oc[i]), 64'(occ));
            chk("stall_cnt_o", i, 64'(sc[i]), 64'(sc_exp[i]));
            chk("flush_cnt_o", i, 64'(fc[i]), 64'(fc_exp[i]));
        end
    endtask

    typedef struct {
        logic        r, s, f, v;
        logic [63:0] d;
        logic        ev;
        logic [63:0] ed;
        logic [2:0]  eo;
        logic [15:0] es, ef;
    } vec_t;

    localparam logic [63:0] A = 64'h0000_0004_2008_0005;
    localparam logic [63:0] B = 64'h0000_0008_0010_0093;
    localparam logic [63:0] C = 64'h0000_000C_0020_8133;
    localparam logic [63:0] D = 64'h0000_0010_4000_01B7;
    localparam logic [63:0] E = 64'h0000_0014_00A5_0513;
    localparam logic [63:0] G = 64'h0000_0018_1111_2222;
    localparam logic [63:0] H = 64'h0000_001C_3333_4444;

    vec_t vt [15];

    initial begin
        logic [1:0]  sat_exp [6];
        logic [63:0] p;
        // Expected outputs of the DEPTH=2 instance (NOP_VALUE = 0x13).
        vt[0]  = '{1, 0, 0, 0, 64'h0,       0, NOP2, 3'd0, 16'd0, 16'd0};
        vt[1]  = '{0, 0, 0, 1, A,           0, NOP2, 3'd1, 16'd0, 16'd0};
        vt[2]  = '{0, 0, 0, 1, B,           1, A,    3'd2, 16'd0, 16'd0};
        vt[3]  = '{0, 1, 0, 1, 64'h1111,    1, A,    3'd2, 16'd1, 16'd0};
        vt[4]  = '{0, 1, 0, 1, 64'h2222,    1, A,    3'd2, 16'd2, 16'd0};
        vt[5]  = '{0, 1, 0, 1, 64'h3333,    1, A,    3'd2, 16'd3, 16'd0};
        vt[6]  = '{0, 0, 0, 1, C,           1, B,    3'd2, 16'd3, 16'd0};
        vt[7]  = '{0, 0, 0, 0, 64'hFFFF,    1, C,    3'd1, 16'd3, 16'd0};
        vt[8]  = '{0, 0, 0, 1, D,           0, NOP2, 3'd1, 16'd3, 16'd0};
        vt[9]  = '{0, 0, 0, 1, E,           1, D,    3'd2, 16'd3, 16'd0};
        vt[10] = '{0, 1, 1, 1, 64'hF0F0,    0, NOP2, 3'd0, 16'd3, 16'd1};
        vt[11] = '{0, 0, 0, 1, G,           0, NOP2, 3'd1, 16'd3, 16'd1};
        vt[12] = '{0, 0, 1, 0, 64'h0,       0, NOP2, 3'd0, 16'd3, 16'd2};
        vt[13] = '{0, 0, 0, 1, G,           0, NOP2, 3'd1, 16'd3, 16'd2};
        vt[14] = '{0, 0, 0, 1, H,           1, G,    3'd2, 16'd3, 16'd2};

        for (int n = 0; n < 15; n++) begin
            step(vt[n].r, vt[n].s, vt[n].f, vt[n].v, vt[n].d);
            chk("tbl_valid", 1, 64'(v2), 64'(vt[n].ev));
            chk("tbl_data", 1, d2, vt[n].ed);
            chk("tbl_occ", 1, 64'(o2), 64'(vt[n].eo));
            chk("tbl_stall_cnt", 1, 64'(s2), 64'(vt[n].es));
            chk("tbl_flush_cnt", 1, 64'(f2), 64'(vt[n].ef));
        end

        // DEPTH=3 stream A..D: A emerges two edges after launch, then B, C, D.
        step(0, 0, 0, 1, A);
        step(0, 0, 0, 1, B);
        step(0, 0, 0, 1, C);
        chk("stream_A", 2, d3, A);
        chk("stream_full", 2, 64'(o3), 64'd3);
        step(0, 0, 0, 1, D);
        chk("stream_B", 2, d3, B);
        step(0, 0, 0, 0, 64'h0);
        chk("stream_C", 2, d3, C);
        step(0, 0, 0, 0, 64'h0);
        chk("stream_D", 2, d3, D);

        // Mid-stream reset with nonzero counters, then normal latency afterwards.
        step(0, 0, 0, 1, E);
        step(0, 1, 0, 1, G);
        step(0, 0, 1, 0, 64'h0);
        step(0, 0, 0, 1, G);
        step(0, 0, 0, 1, H);
        step(1, 0, 0, 1, 64'h5555);
        chk("rst_valid", 3, 64'(v4), 64'd0);
        chk("rst_data", 3, d4, NOP4);
        chk("rst_stall_cnt", 3, 64'(s4), 64'd0);
        p = 64'hCAFE_0000_1234_5678;
        step(0, 0, 0, 1, p);
        chk("post_rst_d1", 0, d1, p);
        step(0, 0, 0, 1, ~p);
        step(0, 0, 0, 1, 64'h77);
        chk("post_rst_d3", 2, d3, p);

        // CNT_W=2 saturation: 1,2,3,3,3,3.
        step(1, 0, 0, 0, 64'h0);
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        for (int n = 0; n < 6; n++) begin
            step(0, 1, 0, 1, 64'(n));
            chk("sat_stall_cnt", 3, 64'(s4), 64'(sat_exp[n]));
        end

        // Random traffic checked by the scoreboard.
        for (int n = 0; n < 300; n++) begin
            logic r, s, f;
            r = ($urandom_range(99) < 2);
            f = ($urandom_range(99) < 6);
            s = ($urandom_range(99) < 15);
            step(r, s, f, 1'($urandom_range(1)), {$urandom, $urandom});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
